// File: rtl/snake_engine.sv
// snake_engine
//   Game-logic core for the snake game. The body is kept as a ring-buffer
//   FIFO of cell indices (head pushed, tail popped), so the tail retraces
//   exactly the path the head took. A parallel occupancy bitmap gives
//   single-cycle self-collision lookup and feeds the renderer directly.
//
// Ports
//   i_Clk           clock, rising edge
//   i_Rst           synchronous active-high reset
//   i_Tick          one-cycle game-step strobe
//   i_Direction     one-hot request: 0001 R, 0010 L, 0100 U, 1000 D
//   i_FoodLocation  next food cell, sampled when food is eaten
//   o_SnakeGrid     occupancy bitmap, bit = y*c_WIDTH + x
//   o_Head          head cell index
//   o_Length        segment count
//   o_Food          current food cell
//   o_Score         foods eaten, saturating
//   o_Eat           one-cycle pulse on an eat step
//   o_Kill          sticky game-over flag
module snake_engine #(
  parameter int c_WIDTH       = 32,
  parameter int c_HEIGHT      = 32,
  parameter int c_GRID_IDX_SZ = 10,
  parameter int c_MAX_LEN     = 64,
  parameter int c_GROW        = 3,
  parameter int c_WRAP        = 0,
  parameter int c_FOOD_INIT   = 0,
  parameter int SCORE_WIDTH   = 14
) (
  input  logic                               i_Clk,
  input  logic                               i_Rst,
  input  logic                               i_Tick,
  input  logic [3:0]                         i_Direction,
  input  logic [c_GRID_IDX_SZ-1:0]           i_FoodLocation,
  output logic [c_WIDTH*c_HEIGHT-1:0]        o_SnakeGrid,
  output logic [c_GRID_IDX_SZ-1:0]           o_Head,
  output logic [$clog2(c_MAX_LEN+1)-1:0]     o_Length,
  output logic [c_GRID_IDX_SZ-1:0]           o_Food,
  output logic [SCORE_WIDTH-1:0]             o_Score,
  output logic                               o_Eat,
  output logic                               o_Kill
);

  localparam int c_CELLS     = c_WIDTH * c_HEIGHT;
  localparam int c_LEN_W     = $clog2(c_MAX_LEN + 1);
  localparam int c_PTR_W     = $clog2(c_MAX_LEN);
  localparam int c_X_W       = $clog2(c_WIDTH);
  localparam int c_Y_W       = $clog2(c_HEIGHT);
  localparam int c_START_INT = (c_HEIGHT / 2) * c_WIDTH + c_WIDTH / 2;

  localparam logic [c_GRID_IDX_SZ-1:0] c_START     = c_GRID_IDX_SZ'(c_START_INT);
  localparam logic [c_CELLS-1:0]       c_GRID_INIT = c_CELLS'(1) << c_START_INT;
  localparam logic [c_LEN_W-1:0]       c_LEN_MAX   = c_LEN_W'(c_MAX_LEN);

  localparam logic [3:0] DIR_STILL = 4'b0000;
  localparam logic [3:0] DIR_RIGHT = 4'b0001;
  localparam logic [3:0] DIR_LEFT  = 4'b0010;
  localparam logic [3:0] DIR_UP    = 4'b0100;
  localparam logic [3:0] DIR_DOWN  = 4'b1000;

  logic [3:0]               dir_q, dir_d;
  logic [c_X_W-1:0]         x_q, x_d;
  logic [c_Y_W-1:0]         y_q, y_d;
  logic [c_GRID_IDX_SZ-1:0] head_q, head_d;
  logic [c_LEN_W-1:0]       len_q, len_d;
  logic [3:0]               pend_q, pend_d;
  logic [c_GRID_IDX_SZ-1:0] food_q, food_d;
  logic [SCORE_WIDTH-1:0]   score_q, score_d;
  logic                     eat_q, eat_d;
  logic                     kill_q, kill_d;
  logic [c_CELLS-1:0]       grid_q, grid_d;
  logic [c_PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [c_PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [c_GRID_IDX_SZ-1:0] fifo_q [c_MAX_LEN];

  logic                     push;
  logic [c_GRID_IDX_SZ-1:0] next_cell;
  logic [c_GRID_IDX_SZ-1:0] tail_cell;
  logic [3:0]               rev_dir;
  logic                     dir_valid;
  logic                     tail_release;
  logic                     out_of_range;
  logic [4:0]               pend_sum;
  int                       nx, ny;

  function automatic logic [c_PTR_W-1:0] ptr_inc(input logic [c_PTR_W-1:0] p);
    return (p == c_PTR_W'(c_MAX_LEN - 1)) ? '0 : p + c_PTR_W'(1);
  endfunction

  assign tail_cell = fifo_q[rd_ptr_q];

  always_comb begin
    dir_d        = dir_q;
    x_d          = x_q;
    y_d          = y_q;
    head_d       = head_q;
    len_d        = len_q;
    pend_d       = pend_q;
    food_d       = food_q;
    score_d      = score_q;
    eat_d        = 1'b0;
    kill_d       = kill_q;
    grid_d       = grid_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    push         = 1'b0;
    pend_sum     = '0;
    rev_dir      = DIR_STILL;
    dir_valid    = 1'b0;
    out_of_range = 1'b0;
    nx           = int'(x_q);
    ny           = int'(y_q);

    // Direction latch; a snake longer than one cell cannot fold back on itself
    case (dir_q)
      DIR_RIGHT: rev_dir = DIR_LEFT;
      DIR_LEFT:  rev_dir = DIR_RIGHT;
      DIR_UP:    rev_dir = DIR_DOWN;
      DIR_DOWN:  rev_dir = DIR_UP;
      default:   rev_dir = DIR_STILL;
    endcase
    dir_valid = (i_Direction == DIR_RIGHT) || (i_Direction == DIR_LEFT) ||
                (i_Direction == DIR_UP)    || (i_Direction == DIR_DOWN);
    if (dir_valid && !((len_q > c_LEN_W'(1)) && (i_Direction == rev_dir)))
      dir_d = i_Direction;

    // Candidate head uses the direction latched before this cycle
    case (dir_q)
      DIR_RIGHT: nx = nx + 1;
      DIR_LEFT:  nx = nx - 1;
      DIR_UP:    ny = ny + 1;
      DIR_DOWN:  ny = ny - 1;
      default:   ;
    endcase
    if (c_WRAP != 0) begin
      if (nx < 0)         nx = c_WIDTH - 1;
      if (nx >= c_WIDTH)  nx = 0;
      if (ny < 0)         ny = c_HEIGHT - 1;
      if (ny >= c_HEIGHT) ny = 0;
    end else begin
      out_of_range = (nx < 0) || (nx >= c_WIDTH) || (ny < 0) || (ny >= c_HEIGHT);
    end
    next_cell = c_GRID_IDX_SZ'(ny * c_WIDTH + nx);

    // The tail leaves this step unless growth is still owed, except at full length
    tail_release = (pend_q == 4'd0) || (len_q == c_LEN_MAX);

    if (i_Tick && !kill_q && (dir_q != DIR_STILL)) begin
      if (out_of_range) begin
        kill_d = 1'b1;
      end else if (grid_q[next_cell] && !(tail_release && (next_cell == tail_cell))) begin
        kill_d = 1'b1;
      end else begin
        push     = 1'b1;
        x_d      = c_X_W'(nx);
        y_d      = c_Y_W'(ny);
        head_d   = next_cell;
        wr_ptr_d = ptr_inc(wr_ptr_q);
        if (tail_release) begin
          rd_ptr_d            = ptr_inc(rd_ptr_q);
          grid_d[tail_cell]   = 1'b0;
        end else begin
          len_d  = len_q + c_LEN_W'(1);
          pend_d = pend_q - 4'd1;
        end
        // Set after the tail clear so a head entering the old tail cell stays lit
        grid_d[next_cell] = 1'b1;
        if (next_cell == food_q) begin
          eat_d    = 1'b1;
          food_d   = i_FoodLocation;
          if (score_q != '1) score_d = score_q + SCORE_WIDTH'(1);
          pend_sum = {1'b0, pend_d} + 5'(c_GROW);
          pend_d   = (pend_sum > 5'd15) ? 4'd15 : pend_sum[3:0];
        end
        if (len_d == c_LEN_MAX) pend_d = 4'd0;
      end
    end
  end

  // State registers; reset re-centres a one-cell snake
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      dir_q    <= DIR_STILL;
      x_q      <= c_X_W'(c_WIDTH / 2);
      y_q      <= c_Y_W'(c_HEIGHT / 2);
      head_q   <= c_START;
      len_q    <= c_LEN_W'(1);
      pend_q   <= 4'd0;
      food_q   <= c_GRID_IDX_SZ'(c_FOOD_INIT);
      score_q  <= '0;
      eat_q    <= 1'b0;
      kill_q   <= 1'b0;
      grid_q   <= c_GRID_INIT;
      rd_ptr_q <= '0;
      wr_ptr_q <= c_PTR_W'(1);
    end else begin
      dir_q    <= dir_d;
      x_q      <= x_d;
      y_q      <= y_d;
      head_q   <= head_d;
      len_q    <= len_d;
      pend_q   <= pend_d;
      food_q   <= food_d;
      score_q  <= score_d;
      eat_q    <= eat_d;
      kill_q   <= kill_d;
      grid_q   <= grid_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  // Body FIFO storage; slot 0 holds the start cell after reset
  always_ff @(posedge i_Clk) begin
    if (i_Rst) fifo_q[0] <= c_START;
    else if (push) fifo_q[wr_ptr_q] <= next_cell;
  end

  assign o_SnakeGrid = grid_q;
  assign o_Head      = head_q;
  assign o_Length    = len_q;
  assign o_Food      = food_q;
  assign o_Score     = score_q;
  assign o_Eat       = eat_q;
  assign o_Kill      = kill_q;

endmodule

// File: tb/tb_snake_engine.sv
// tb_snake_engine
//   Drives an 8x8 wall-kill engine and a wrap-around twin with the same
//   inputs. Directed table rows and hand sequences cover the game rules;
//   a random phase compares both against a list-of-cells snake model.
module tb_snake_engine;

  localparam logic [3:0] R = 4'b0001;
  localparam logic [3:0] L = 4'b0010;
  localparam logic [3:0] U = 4'b0100;
  localparam logic [3:0] D = 4'b1000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tick = 1'b0;
  logic [3:0]  dir = 4'b0;
  logic [5:0]  food = 6'd0;

  logic [63:0] grid0, grid1;
  logic [5:0]  head0, head1, food0, food1;
  logic [3:0]  len0, len1;
  logic [13:0] score0, score1;
  logic        eat0, eat1, kill0, kill1;

  int total = 0;
  int bad = 0;
  bit modelOn = 1'b0;

  // Reference model: body as an ordered list, head first
  int mBody [2][8];
  int mLen [2];
  int mPend [2];
  int mDir [2];
  int mFood [2];
  int mScore [2];
  int mEat [2];
  int mKill [2];

  typedef struct {
    logic        rst;
    logic        tick;
    logic [3:0]  dir;
    logic [5:0]  food;
    logic [5:0]  expHead;
    logic [3:0]  expLen;
    logic [63:0] expGrid;
    logic [5:0]  expFood;
    logic [13:0] expScore;
    logic        expEat;
    logic        expKill;
  } vec_t;

  vec_t vecs [22];

  snake_engine #(
    .c_WIDTH(8), .c_HEIGHT(8), .c_GRID_IDX_SZ(6), .c_MAX_LEN(8), .c_GROW(2),
    .c_WRAP(0), .c_FOOD_INIT(38), .SCORE_WIDTH(14)
  ) dut (
    .i_Clk(clk), .i_Rst(rst), .i_Tick(tick), .i_Direction(dir), .i_FoodLocation(food),
    .o_SnakeGrid(grid0), .o_Head(head0), .o_Length(len0), .o_Food(food0),
    .o_Score(score0), .o_Eat(eat0), .o_Kill(kill0)
  );

  snake_engine #(
    .c_WIDTH(8), .c_HEIGHT(8), .c_GRID_IDX_SZ(6), .c_MAX_LEN(8), .c_GROW(2),
    .c_WRAP(1), .c_FOOD_INIT(38), .SCORE_WIDTH(14)
  ) dutWrap (
    .i_Clk(clk), .i_Rst(rst), .i_Tick(tick), .i_Direction(dir), .i_FoodLocation(food),
    .o_SnakeGrid(grid1), .o_Head(head1), .o_Length(len1), .o_Food(food1),
    .o_Score(score1), .o_Eat(eat1), .o_Kill(kill1)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] bitOf(input int c);
    return 64'd1 << c;
  endfunction

  function automatic int opposite(input int d);
    case (d)
      1: return 2;
      2: return 1;
      3: return 4;
      4: return 3;
      default: return 0;
    endcase
  endfunction

  function automatic logic [63:0] modelGrid(input int i);
    logic [63:0] g = '0;
    for (int k = 0; k < mLen[i]; k++) g[mBody[i][k]] = 1'b1;
    return g;
  endfunction

  task automatic modelStep(input int i, input bit wrap, input logic r, input logic t,
                           input logic [3:0] d, input logic [5:0] f);
    int req, newDir, hx, hy, nxt;
    bit off, occ, rel;
    if (r) begin
      mBody[i][0] = 36; mLen[i] = 1; mPend[i] = 0; mDir[i] = 0;
      mFood[i] = 38; mScore[i] = 0; mEat[i] = 0; mKill[i] = 0;
      return;
    end
    req = (d == R) ? 1 : (d == L) ? 2 : (d == U) ? 3 : (d == D) ? 4 : 0;
    newDir = mDir[i];
    if (req != 0 && !(mLen[i] > 1 && req == opposite(mDir[i]))) newDir = req;
    mEat[i] = 0;
    if (t && mKill[i] == 0 && mDir[i] != 0) begin
      hx = mBody[i][0] % 8;
      hy = mBody[i][0] / 8;
      case (mDir[i])
        1: hx++;
        2: hx--;
        3: hy++;
        default: hy--;
      endcase
      off = (hx < 0) || (hx > 7) || (hy < 0) || (hy > 7);
      if (off && wrap) begin
        hx = (hx + 8) % 8;
        hy = (hy + 8) % 8;
        off = 1'b0;
      end
      if (off) begin
        mKill[i] = 1;
      end else begin
        nxt = hy * 8 + hx;
        rel = (mPend[i] == 0) || (mLen[i] == 8);
        occ = 1'b0;
        for (int k = 0; k < mLen[i]; k++) if (mBody[i][k] == nxt) occ = 1'b1;
        if (occ && !(rel && nxt == mBody[i][mLen[i]-1])) begin
          mKill[i] = 1;
        end else begin
          if (!rel) begin
            mLen[i]++;
            mPend[i]--;
          end
          for (int k = mLen[i] - 1; k > 0; k--) mBody[i][k] = mBody[i][k-1];
          mBody[i][0] = nxt;
          if (nxt == mFood[i]) begin
            mEat[i] = 1;
            if (mScore[i] < 16383) mScore[i]++;
            mFood[i] = int'(f);
            mPend[i] = (mPend[i] + 2 > 15) ? 15 : mPend[i] + 2;
          end
          if (mLen[i] == 8) mPend[i] = 0;
        end
      end
    end
    mDir[i] = newDir;
  endtask

  task automatic applyStimulus(input logic r, input logic t, input logic [3:0] d,
                               input logic [5:0] f);
    @(negedge clk);
    rst = r; tick = t; dir = d; food = f;
    if (modelOn) begin
      modelStep(0, 1'b0, r, t, d, f);
      modelStep(1, 1'b1, r, t, d, f);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Latch a direction in one cycle, step with it on the next
  task automatic move(input logic [3:0] d, input logic [5:0] f);
    applyStimulus(1'b0, 1'b0, d, f);
    applyStimulus(1'b0, 1'b1, 4'b0, f);
  endtask

  task automatic compareInst(input int i, input int cyc, input logic [5:0] h, input logic [3:0] ln,
                             input logic [63:0] g, input logic [5:0] fd, input logic [13:0] sc,
                             input logic e, input logic k);
    checkOutput($sformatf("rnd%0d.u%0d.head", cyc, i), 64'(h), 64'(mBody[i][0]));
    checkOutput($sformatf("rnd%0d.u%0d.len", cyc, i), 64'(ln), 64'(mLen[i]));
    checkOutput($sformatf("rnd%0d.u%0d.grid", cyc, i), g, modelGrid(i));
    checkOutput($sformatf("rnd%0d.u%0d.food", cyc, i), 64'(fd), 64'(mFood[i]));
    checkOutput($sformatf("rnd%0d.u%0d.score", cyc, i), 64'(sc), 64'(mScore[i]));
    checkOutput($sformatf("rnd%0d.u%0d.eat", cyc, i), 64'(e), 64'(mEat[i]));
    checkOutput($sformatf("rnd%0d.u%0d.kill", cyc, i), 64'(k), 64'(mKill[i]));
  endtask

  initial begin
    logic [3:0] rd;
    int pick;

    //            rst   tick  dir   food   head   len   grid                                       food   score  eat   kill
    vecs[0]  = '{1'b1, 1'b0, 4'b0, 6'd0,  6'd36, 4'd1, bitOf(36),                                 6'd38, 14'd0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, R,    6'd0,  6'd36, 4'd1, bitOf(36),                                 6'd38, 14'd0, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 4'b0, 6'd0,  6'd37, 4'd1, bitOf(37),                                 6'd38, 14'd0, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, U,    6'd10, 6'd38, 4'd1, bitOf(38),                                 6'd10, 14'd1, 1'b1, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 4'b0, 6'd0,  6'd46, 4'd2, bitOf(38)|bitOf(46),                       6'd10, 14'd1, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 4'b0, 6'd0,  6'd54, 4'd3, bitOf(38)|bitOf(46)|bitOf(54),             6'd10, 14'd1, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, D,    6'd0,  6'd54, 4'd3, bitOf(38)|bitOf(46)|bitOf(54),             6'd10, 14'd1, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 4'b0, 6'd0,  6'd62, 4'd3, bitOf(46)|bitOf(54)|bitOf(62),             6'd10, 14'd1, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 4'b0, 6'd0,  6'd62, 4'd3, bitOf(46)|bitOf(54)|bitOf(62),             6'd10, 14'd1, 1'b0, 1'b1};
    vecs[9]  = '{1'b0, 1'b1, R,    6'd0,  6'd62, 4'd3, bitOf(46)|bitOf(54)|bitOf(62),             6'd10, 14'd1, 1'b0, 1'b1};
    vecs[10] = '{1'b1, 1'b1, R,    6'd0,  6'd36, 4'd1, bitOf(36),                                 6'd38, 14'd0, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 4'b0, 6'd0,  6'd36, 4'd1, bitOf(36),                                 6'd38, 14'd0, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 1'b0, R,    6'd0,  6'd36, 4'd1, bitOf(36),                                 6'd38, 14'd0, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 1'b0, L,    6'd0,  6'd36, 4'd1, bitOf(36),                                 6'd38, 14'd0, 1'b0, 1'b0};
    vecs[14] = '{1'b0, 1'b1, 4'b0, 6'd0,  6'd35, 4'd1, bitOf(35),                                 6'd38, 14'd0, 1'b0, 1'b0};
    vecs[15] = '{1'b1, 1'b0, 4'b0, 6'd0,  6'd36, 4'd1, bitOf(36),                                 6'd38, 14'd0, 1'b0, 1'b0};
    vecs[16] = '{1'b0, 1'b0, R,    6'd0,  6'd36, 4'd1, bitOf(36),                                 6'd38, 14'd0, 1'b0, 1'b0};
    vecs[17] = '{1'b0, 1'b1, 4'b0, 6'd0,  6'd37, 4'd1, bitOf(37),                                 6'd38, 14'd0, 1'b0, 1'b0};
    vecs[18] = '{1'b0, 1'b1, 4'b0, 6'd20, 6'd38, 4'd1, bitOf(38),                                 6'd20, 14'd1, 1'b1, 1'b0};
    vecs[19] = '{1'b0, 1'b1, 4'b0, 6'd0,  6'd39, 4'd2, bitOf(38)|bitOf(39),                       6'd20, 14'd1, 1'b0, 1'b0};
    vecs[20] = '{1'b0, 1'b1, 4'b0, 6'd0,  6'd39, 4'd2, bitOf(38)|bitOf(39),                       6'd20, 14'd1, 1'b0, 1'b1};
    vecs[21] = '{1'b0, 1'b1, 4'b0, 6'd0,  6'd39, 4'd2, bitOf(38)|bitOf(39),                       6'd20, 14'd1, 1'b0, 1'b1};

    $display("[TB] directed table");
    for (int i = 0; i < 22; i++) begin
      applyStimulus(vecs[i].rst, vecs[i].tick, vecs[i].dir, vecs[i].food);
      checkOutput($sformatf("v%0d.head", i), 64'(head0), 64'(vecs[i].expHead));
      checkOutput($sformatf("v%0d.len", i), 64'(len0), 64'(vecs[i].expLen));
      checkOutput($sformatf("v%0d.grid", i), grid0, vecs[i].expGrid);
      checkOutput($sformatf("v%0d.food", i), 64'(food0), 64'(vecs[i].expFood));
      checkOutput($sformatf("v%0d.score", i), 64'(score0), 64'(vecs[i].expScore));
      checkOutput($sformatf("v%0d.eat", i), 64'(eat0), 64'(vecs[i].expEat));
      checkOutput($sformatf("v%0d.kill", i), 64'(kill0), 64'(vecs[i].expKill));
      if (i == 20) begin
        checkOutput("wrap.head", 64'(head1), 64'd32);
        checkOutput("wrap.len", 64'(len1), 64'd3);
        checkOutput("wrap.kill", 64'(kill1), 64'd0);
      end
    end

    $display("[TB] self-collision sequence");
    applyStimulus(1'b1, 1'b0, 4'b0, 6'd0);
    move(R, 6'd0);
    move(4'b0, 6'd39);
    move(4'b0, 6'd63);
    checkOutput("sc.eat2", 64'(eat0), 64'd1);
    checkOutput("sc.score2", 64'(score0), 64'd2);
    checkOutput("sc.len2", 64'(len0), 64'd2);
    move(U, 6'd0);
    move(4'b0, 6'd0);
    move(L, 6'd0);
    checkOutput("sc.len5", 64'(len0), 64'd5);
    checkOutput("sc.head54", 64'(head0), 64'd54);
    move(4'b0, 6'd0);
    move(D, 6'd0);
    move(4'b0, 6'd0);
    move(R, 6'd0);
    move(4'b0, 6'd0);
    move(U, 6'd0);
    move(L, 6'd0);
    checkOutput("sc.alive", 64'(kill0), 64'd0);
    move(D, 6'd0);
    checkOutput("sc.kill", 64'(kill0), 64'd1);
    checkOutput("sc.head", 64'(head0), 64'd46);
    checkOutput("sc.len", 64'(len0), 64'd5);
    checkOutput("sc.grid", grid0, bitOf(46)|bitOf(47)|bitOf(39)|bitOf(38)|bitOf(37));

    $display("[TB] max-length and tail-chase sequence");
    applyStimulus(1'b1, 1'b0, 4'b0, 6'd0);
    move(R, 6'd0);
    move(4'b0, 6'd39);
    move(4'b0, 6'd47);
    move(U, 6'd46);
    move(L, 6'd34);
    checkOutput("ml.score4", 64'(score0), 64'd4);
    checkOutput("ml.len4", 64'(len0), 64'd4);
    move(4'b0, 6'd0);
    move(4'b0, 6'd0);
    move(4'b0, 6'd0);
    move(4'b0, 6'd0);
    checkOutput("ml.len8", 64'(len0), 64'd8);
    move(4'b0, 6'd0);
    checkOutput("ml.len8hold", 64'(len0), 64'd8);
    checkOutput("ml.head41", 64'(head0), 64'd41);
    move(D, 6'd0);
    move(R, 6'd63);
    checkOutput("ml.eatAtMax", 64'(eat0), 64'd1);
    checkOutput("ml.score5", 64'(score0), 64'd5);
    checkOutput("ml.lenAtMax", 64'(len0), 64'd8);
    checkOutput("ml.food63", 64'(food0), 64'd63);
    move(4'b0, 6'd0);
    move(4'b0, 6'd0);
    move(U, 6'd0);
    checkOutput("ml.tailChaseKill", 64'(kill0), 64'd0);
    checkOutput("ml.tailChaseHead", 64'(head0), 64'd44);
    checkOutput("ml.tailChaseLen", 64'(len0), 64'd8);
    checkOutput("ml.tailChaseGrid", grid0,
                bitOf(44)|bitOf(36)|bitOf(35)|bitOf(34)|bitOf(33)|bitOf(41)|bitOf(42)|bitOf(43));
    applyStimulus(1'b1, 1'b1, R, 6'd5);
    checkOutput("rst.head", 64'(head0), 64'd36);
    checkOutput("rst.len", 64'(len0), 64'd1);
    checkOutput("rst.grid", grid0, bitOf(36));
    checkOutput("rst.food", 64'(food0), 64'd38);
    checkOutput("rst.score", 64'(score0), 64'd0);
    checkOutput("rst.eat", 64'(eat0), 64'd0);
    checkOutput("rst.kill", 64'(kill0), 64'd0);
    applyStimulus(1'b0, 1'b1, 4'b0, 6'd0);
    checkOutput("rst.still", 64'(head0), 64'd36);

    $display("[TB] random phase");
    modelOn = 1'b1;
    applyStimulus(1'b1, 1'b0, 4'b0, 6'd0);
    compareInst(0, 0, head0, len0, grid0, food0, score0, eat0, kill0);
    compareInst(1, 0, head1, len1, grid1, food1, score1, eat1, kill1);
    for (int c = 1; c <= 3000; c++) begin
      pick = int'($urandom_range(0, 9));
      if (pick < 5)      rd = 4'b0001 << $urandom_range(0, 3);
      else if (pick < 7) rd = 4'b0;
      else               rd = 4'($urandom_range(0, 15));
      applyStimulus(($urandom_range(0, 149) == 0), ($urandom_range(0, 2) != 0), rd,
                    6'($urandom_range(0, 63)));
      compareInst(0, c, head0, len0, grid0, food0, score0, eat0, kill0);
      compareInst(1, c, head1, len1, grid1, food1, score1, eat1, kill1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/snake_engine.md
# snake_engine

Parametrised game-logic core for the snake game. It holds the snake body in a ring-buffer FIFO of cell indices, so the tail always retraces the exact path the head took. It adds configurable grid size, maximum length, growth per food, wall-kill or wrap-around mode, self-collision detection and reversal rejection. It sits between the direction decoder and food generator upstream and the grid renderer and score display downstream.

## Interface
- c_WIDTH, 32, grid columns (x)
- c_HEIGHT, 32, grid rows (y)
- c_GRID_IDX_SZ, 10, cell-index width; 2^c_GRID_IDX_SZ >= c_WIDTH*c_HEIGHT
- c_MAX_LEN, 64, body FIFO depth = maximum snake length, >= 2
- c_GROW, 3, segments added per food eaten, 1..15
- c_WRAP, 0, 0 = leaving the grid kills; 1 = head wraps to the opposite edge
- c_FOOD_INIT, 0, o_Food value after reset
- SCORE_WIDTH, 14, score counter width
- i_Clk  in  1  clock, rising edge
- i_Rst  in  1  reset, synchronous, active-high
- i_Tick  in  1  one-cycle game-step strobe
- i_Direction  in  4  one-hot request: 0001 RIGHT (x+1), 0010 LEFT (x-1), 0100 UP (y+1), 1000 DOWN (y-1); any other value is ignored
- i_FoodLocation  in  c_GRID_IDX_SZ  next food cell, sampled on an eat step
- o_SnakeGrid  out  c_WIDTH*c_HEIGHT  occupancy bitmap; bit index = y*c_WIDTH + x
- o_Head  out  c_GRID_IDX_SZ  current head cell index
- o_Length  out  $clog2(c_MAX_LEN+1)  current segment count
- o_Food  out  c_GRID_IDX_SZ  current food cell
- o_Score  out  SCORE_WIDTH  foods eaten, saturates at all-ones
- o_Eat  out  1  one-cycle pulse on an eat step
- o_Kill  out  1  sticky game-over flag

## Operation
- Reset values:
  - Head x = c_WIDTH/2, y = c_HEIGHT/2; FIFO holds that single cell; o_Length = 1; o_SnakeGrid has only the head bit set.
  - r_Dir = STILL; pending-growth counter = 0; o_Food = c_FOOD_INIT; o_Score = 0; o_Eat = 0; o_Kill = 0.
- Direction latch, every cycle:
  - A valid one-hot i_Direction is loaded into r_Dir.
  - Exception: when o_Length > 1, the exact reverse of r_Dir is rejected and r_Dir is held.
- Step: occurs when i_Tick = 1, o_Kill = 0 and r_Dir != STILL. Otherwise all state is held and o_Eat = 0.
- Next head: x/y ±1 per r_Dir.
  - c_WRAP = 0: x or y out of range sets o_Kill; no other state changes.
  - c_WRAP = 1: coordinates wrap modulo c_WIDTH / c_HEIGHT.
- Tail release: release = (pending == 0) or (o_Length == c_MAX_LEN).
- Self-collision: the next cell is set in o_SnakeGrid and is not (the tail cell with release = 1). On collision, o_Kill is set and no other state changes.
- Legal move:
  - Push the next cell into the FIFO, set its grid bit, update o_Head.
  - If release: pop the tail and clear its grid bit. A popped tail equal to the new head keeps its bit set.
  - Otherwise: o_Length +1 and pending −1.
  - At o_Length == c_MAX_LEN, pending is cleared.
- Eat: the next cell equals o_Food on a legal move.
  - o_Eat = 1; o_Score +1 (saturating); o_Food <= i_FoodLocation.
  - pending <= pending − consumed + c_GROW, saturating at 4-bit max.
- Food placement is the generator's responsibility. No check is made against the body. An out-of-range food index is simply never reached.
- FIFO: read/write pointers mod c_MAX_LEN; count = o_Length. It is never popped below 1 and never pushed beyond c_MAX_LEN.

## Timing
- All outputs are registered. A step's results are visible the cycle after the i_Tick edge.
- A direction change takes effect on the first tick after it is latched. Direction and tick may arrive in the same cycle; the step then uses the pre-latch r_Dir.
- o_Eat is high exactly one cycle per eat step.
- o_Kill stays asserted until i_Rst. Ticks while killed are ignored.
- i_Rst mid-game: the next cycle equals the reset state, regardless of any tick in the reset cycle.

## Test plan
Parameters for all scenarios: c_WIDTH = c_HEIGHT = 8, c_MAX_LEN = 8, c_GROW = 2, c_FOOD_INIT = 38, c_WRAP = 0 unless stated.
1. Reset, then RIGHT + one tick -> o_Head 36→37, o_Length 1, only bit 37 set, o_Kill 0.
2. RIGHT, two ticks, i_FoodLocation = 10 -> tick 2 gives o_Eat pulse, o_Score 1, o_Food 10. The next two ticks raise o_Length to 2 then 3, and the tail bits stay set.
3. From length 3 moving RIGHT, apply LEFT -> r_Dir stays RIGHT and the head keeps advancing. With length 1, LEFT is accepted.
4. RIGHT, four ticks from 36 -> the fourth tick (x=8) sets o_Kill, o_Head stays 39, and later ticks change nothing. With c_WRAP = 1, o_Head becomes 32.
5. Grow to length 5, then steer UP, LEFT, DOWN -> head re-enters its own body and o_Kill is set. A move into the releasing tail cell does not kill.
6. Eat repeatedly until o_Length = 8 -> length holds at 8, pending is cleared, and o_Score still counts. i_Rst mid-game restores every reset value next cycle.
